// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with busy scoreboard
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                       clock,
  input  logic                       ctrl_reset,
  input  logic                       ctrl_writeEn0,
  input  logic [ADDR_W-1:0]          ctrl_writeReg0,
  input  logic [WIDTH-1:0]           data_writeReg0,
  input  logic                       ctrl_writeEn1,
  input  logic [ADDR_W-1:0]          ctrl_writeReg1,
  input  logic [WIDTH-1:0]           data_writeReg1,
  input  logic                       ctrl_reserveEn,
  input  logic [ADDR_W-1:0]          ctrl_reserveReg,
  input  logic [NUM_READ*ADDR_W-1:0] ctrl_readReg,
  output logic [NUM_READ*WIDTH-1:0]  data_readReg,
  output logic [NUM_READ-1:0]        busy_read,
  output logic                       busy_any
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q;

  // Per-register decode of the two write ports and the reserve port.
  // Addresses >= DEPTH never match any r, so they fall away naturally.
  logic [DEPTH-1:0] hit0_d, hit1_d, res_d;

  // Decode which registers each port targets this cycle (register 0 excluded when hardwired)
  always_comb begin
    hit0_d = '0;
    hit1_d = '0;
    res_d  = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (!(ZERO_REG && r == 0)) begin
        hit0_d[r] = ctrl_writeEn0  && (ctrl_writeReg0  == ADDR_W'(r));
        hit1_d[r] = ctrl_writeEn1  && (ctrl_writeReg1  == ADDR_W'(r));
        res_d[r]  = ctrl_reserveEn && (ctrl_reserveReg == ADDR_W'(r));
      end
    end
  end

  // Register storage and busy scoreboard; port 1 wins a same-address write, reserve wins over write
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (hit1_d[r]) begin
          regs_q[r] <= data_writeReg1;
        end else if (hit0_d[r]) begin
          regs_q[r] <= data_writeReg0;
        end
        if (res_d[r]) begin
          busy_q[r] <= 1'b1;
        end else if (hit0_d[r] || hit1_d[r]) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  // Combinational read ports with optional same-cycle bypass; zero/out-of-range/reset force 0
  always_comb begin
    data_readReg = '0;
    busy_read    = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      logic [ADDR_W-1:0] addr;
      logic [WIDTH-1:0]  rdata;
      logic              rbusy;
      logic              found;
      logic              wr_act;
      logic              rs_act;
      addr   = ctrl_readReg[i*ADDR_W +: ADDR_W];
      rdata  = '0;
      rbusy  = 1'b0;
      found  = 1'b0;
      for (int r = 0; r < DEPTH; r++) begin
        if (addr == ADDR_W'(r) && !(ZERO_REG && r == 0)) begin
          rdata = regs_q[r];
          rbusy = busy_q[r];
          found = 1'b1;
        end
      end
      wr_act = (ctrl_writeEn1 && ctrl_writeReg1 == addr) ||
               (ctrl_writeEn0 && ctrl_writeReg0 == addr);
      rs_act = ctrl_reserveEn && ctrl_reserveReg == addr;
      if (BYPASS) begin
        if (ctrl_writeEn1 && ctrl_writeReg1 == addr) begin
          rdata = data_writeReg1;
        end else if (ctrl_writeEn0 && ctrl_writeReg0 == addr) begin
          rdata = data_writeReg0;
        end
        if (wr_act && !rs_act) begin
          rbusy = 1'b0;
        end
      end
      if (found && !ctrl_reset) begin
        data_readReg[i*WIDTH +: WIDTH] = rdata;
        busy_read[i]                   = rbusy;
      end
    end
  end

  assign busy_any = |busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        en0, en1, res_en;
  logic [4:0]  a0, a1, res_a;
  logic [31:0] d0, d1;
  logic [9:0]  rd2;
  logic [19:0] rd4;

  logic [63:0]  dr_a, dr_b;
  logic [1:0]   br_a, br_b;
  logic         ba_a, ba_b;
  logic [127:0] dr_c;
  logic [3:0]   br_c;
  logic         ba_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // default: bypass on, 32 deep, 2 read ports
  regfile_mp u_byp (
    .clock(clk), .ctrl_reset(rst),
    .ctrl_writeEn0(en0), .ctrl_writeReg0(a0), .data_writeReg0(d0),
    .ctrl_writeEn1(en1), .ctrl_writeReg1(a1), .data_writeReg1(d1),
    .ctrl_reserveEn(res_en), .ctrl_reserveReg(res_a),
    .ctrl_readReg(rd2), .data_readReg(dr_a), .busy_read(br_a), .busy_any(ba_a)
  );

  // bypass off
  regfile_mp #(.BYPASS(1'b0)) u_nob (
    .clock(clk), .ctrl_reset(rst),
    .ctrl_writeEn0(en0), .ctrl_writeReg0(a0), .data_writeReg0(d0),
    .ctrl_writeEn1(en1), .ctrl_writeReg1(a1), .data_writeReg1(d1),
    .ctrl_reserveEn(res_en), .ctrl_reserveReg(res_a),
    .ctrl_readReg(rd2), .data_readReg(dr_b), .busy_read(br_b), .busy_any(ba_b)
  );

  // 16 deep, 4 read ports
  regfile_mp #(.DEPTH(16), .NUM_READ(4)) u_d16 (
    .clock(clk), .ctrl_reset(rst),
    .ctrl_writeEn0(en0), .ctrl_writeReg0(a0), .data_writeReg0(d0),
    .ctrl_writeEn1(en1), .ctrl_writeReg1(a1), .data_writeReg1(d1),
    .ctrl_reserveEn(res_en), .ctrl_reserveReg(res_a),
    .ctrl_readReg(rd4), .data_readReg(dr_c), .busy_read(br_c), .busy_any(ba_c)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    en0 = 1'b0; en1 = 1'b0; res_en = 1'b0;
    a0 = '0; a1 = '0; res_a = '0; d0 = '0; d1 = '0;
  endtask

  task automatic read_all(input logic [4:0] a);
    rd2 = {a, a};
    rd4 = {a, a, a, a};
  endtask

  initial begin
    idle();
    read_all(5'd0);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check("in_reset_busy_any", ba_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // reset state on every address, all ports
    for (int a = 0; a < 32; a++) begin
      read_all(5'(a));
      #1;
      check("rst_data_byp", dr_a, 64'h0);
      check("rst_busy_byp", br_a, 2'b00);
    end
    check("rst_busy_any", {ba_a, ba_b, ba_c}, 3'b000);
    check("rst_data_d16", dr_c, 128'h0);
    @(negedge clk);

    // dual write to r5, port 1 wins
    en0 = 1'b1; a0 = 5'd5; d0 = 32'hDEADBEEF;
    en1 = 1'b1; a1 = 5'd5; d1 = 32'h12345678;
    read_all(5'd5);
    #2;
    check("dual_bypass_same", dr_a, {2{32'h12345678}});
    check("dual_nobyp_same", dr_b, 64'h0);
    @(negedge clk);
    idle();
    #2;
    check("dual_byp_next", dr_a, {2{32'h12345678}});
    check("dual_nob_next", dr_b, {2{32'h12345678}});
    check("dual_d16_next", dr_c, {4{32'h12345678}});

    // r0 is hardwired zero
    en0 = 1'b1; a0 = 5'd0; d0 = 32'd7;
    read_all(5'd0);
    #2;
    check("r0_bypass", dr_a, 64'h0);
    @(negedge clk);
    idle();
    #2;
    check("r0_stored", dr_a, 64'h0);
    check("r0_stored_nob", dr_b, 64'h0);

    // bypass vs no bypass on r3
    @(negedge clk);
    en0 = 1'b1; a0 = 5'd3; d0 = 32'd42;
    rd2 = {5'd0, 5'd3};
    #2;
    check("r3_byp_same", dr_a[31:0], 32'd42);
    check("r3_byp_port1_r0", dr_a[63:32], 32'd0);
    check("r3_nob_same", dr_b[31:0], 32'd0);
    @(negedge clk);
    idle();
    #2;
    check("r3_nob_next", dr_b[31:0], 32'd42);

    // reserve r7
    @(negedge clk);
    res_en = 1'b1; res_a = 5'd7;
    read_all(5'd7);
    #2;
    check("r7_busy_before_edge", br_a, 2'b00);
    @(negedge clk);
    idle();
    #2;
    check("r7_busy", br_a, 2'b11);
    check("r7_busy_any", {ba_a, ba_b, ba_c}, 3'b111);
    // write r7 = 9 clears busy
    en0 = 1'b1; a0 = 5'd7; d0 = 32'd9;
    #1;
    check("r7_wr_busy_byp", br_a, 2'b00);
    check("r7_wr_busy_nob", br_b, 2'b11);
    @(negedge clk);
    idle();
    #2;
    check("r7_cleared", {br_a, br_b}, 4'b0000);
    check("r7_busy_any0", {ba_a, ba_b, ba_c}, 3'b000);
    check("r7_data9", dr_b[31:0], 32'd9);
    // reserve and write together: busy stays, data updates
    en0 = 1'b1; a0 = 5'd7; d0 = 32'd11;
    res_en = 1'b1; res_a = 5'd7;
    #1;
    check("r7_rsv_wr_busy_same", br_a, 2'b00);
    @(negedge clk);
    idle();
    #2;
    check("r7_rsv_wr_busy", {br_a, br_b}, 4'b1111);
    check("r7_rsv_wr_data", dr_b, {2{32'd11}});
    // release r7 via port 1
    en1 = 1'b1; a1 = 5'd7; d1 = 32'd0;
    @(negedge clk);
    idle();

    // out-of-range on the 16-deep instance
    en0 = 1'b1; a0 = 5'd20; d0 = 32'd5;
    read_all(5'd20);
    #2;
    check("oor_bypass_d16", dr_c, 128'h0);
    @(negedge clk);
    idle();
    #2;
    check("oor_read_d16", dr_c, 128'h0);
    check("oor_read_byp32", dr_a, {2{32'd5}});
    res_en = 1'b1; res_a = 5'd20;
    @(negedge clk);
    idle();
    #2;
    check("oor_reserve_busy_any", {ba_a, ba_c}, 2'b10);
    check("oor_reserve_busy_read", {br_a, br_c}, 6'b110000);
    res_en = 1'b1; res_a = 5'd0;
    @(negedge clk);
    idle();
    #2;
    check("r0_reserve_d16", ba_c, 1'b0);
    // four ports reading r2
    en1 = 1'b1; a1 = 5'd2; d1 = 32'hA5;
    @(negedge clk);
    idle();
    read_all(5'd2);
    #2;
    check("quad_r2", dr_c, {4{32'hA5}});

    // mid-cycle reset
    en0 = 1'b1; a0 = 5'd10; d0 = 32'd100;
    @(negedge clk);
    idle();
    read_all(5'd10);
    #1;
    check("r10_written", dr_b, {2{32'd100}});
    rst = 1'b1;
    #1;
    check("r10_async_clear", {dr_a, dr_b}, 128'h0);
    check("async_busy_any", {ba_a, ba_b, ba_c}, 3'b000);
    en0 = 1'b1; a0 = 5'd10; d0 = 32'd55;
    #1;
    check("bypass_in_reset", dr_a, 64'h0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    #2;
    check("r10_after_reset", {dr_a, dr_b}, 128'h0);
    en1 = 1'b1; a1 = 5'd10; d1 = 32'h77;
    @(negedge clk);
    idle();
    #2;
    check("first_write_after_reset", dr_b, {2{32'h77}});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the processor datapath, succeeding the fixed 32×32, two-read/one-write register file. Adds configurable width, depth and read-port count, a second write port for late-retiring results (e.g. multdiv), optional same-cycle write-to-read bypass, and a per-register busy scoreboard so the hazard unit can stall on pending writes. Sits between decode (read ports, reserve) and writeback (write ports).

## Interface
- WIDTH, 32, data bits per register
- DEPTH, 32, number of registers; 2 ≤ DEPTH ≤ 2^ADDR_W
- ADDR_W, 5, address bits per port
- NUM_READ, 2, number of read ports (1..8)
- BYPASS, 1, 1 = read returns same-cycle write data; 0 = read returns stored value
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and reservations

- clock  in  1  single clock; all state updates on rising edge
- ctrl_reset  in  1  asynchronous, active-high reset
- ctrl_writeEn0  in  1  write port 0 enable
- ctrl_writeReg0  in  ADDR_W  write port 0 address
- data_writeReg0  in  WIDTH  write port 0 data
- ctrl_writeEn1  in  1  write port 1 enable
- ctrl_writeReg1  in  ADDR_W  write port 1 address
- data_writeReg1  in  WIDTH  write port 1 data
- ctrl_reserveEn  in  1  mark a register as pending-write
- ctrl_reserveReg  in  ADDR_W  register to reserve
- ctrl_readReg  in  NUM_READ*ADDR_W  read addresses; port i at [i*ADDR_W +: ADDR_W]
- data_readReg  out  NUM_READ*WIDTH  read data; port i at [i*WIDTH +: WIDTH]
- busy_read  out  NUM_READ  busy bit of the register addressed by each read port
- busy_any  out  1  OR of all busy bits

## Operation
- Storage: DEPTH×WIDTH flops plus DEPTH busy bits.
- Reset (async, active-high): all registers = 0, all busy = 0, immediately while ctrl_reset high; all writes/reserves ignored during reset. Outputs: data_readReg = 0, busy_read = 0, busy_any = 0.
- Write: on rising edge, each enabled port with valid address stores its data.
- Same-address dual write: port 1 wins; port 0 data discarded.
- Address ≥ DEPTH: write and reserve ignored; read returns 0, busy 0.
- ZERO_REG=1: address 0 write/reserve ignored; read returns 0, busy 0 always.
- Read (combinational, per port independent; any ports may share an address):
  - BYPASS=1: if write port 1 enabled to that address, return data_writeReg1; else if port 0 enabled to that address, return data_writeReg0; else stored value.
  - BYPASS=0: stored value only.
  - Zero/out-of-range rules override bypass.
- Scoreboard, per register r, on rising edge:
  - reserve to r → busy[r] = 1 (takes priority over a same-cycle write to r).
  - else any enabled write to r → busy[r] = 0.
  - else hold.
- busy_read[i] = busy bit of addressed register as currently stored; with BYPASS=1 it reads 0 when a write to that register is active this cycle and no reserve to it is active.

## Timing
- Write latency: data visible at read port after the next rising edge (BYPASS=0) or combinationally in the same cycle (BYPASS=1).
- Reserve latency: busy visible after the next rising edge.
- Read path purely combinational from ctrl_readReg / write inputs to data_readReg.
- Reset assertion mid-cycle clears state without waiting for clock; first write accepted on the first rising edge with ctrl_reset low.
- Bench convention: drive inputs after negedge, sample outputs at following negedge.

## Test plan
- Reset then read all addresses on all ports → every data_readReg = 0, busy_read = 0, busy_any = 0.
- Write 0xDEADBEEF to r5 via port 0, 0x12345678 to r5 via port 1 same cycle → r5 reads 0x12345678 next cycle; write r0 = 7 → r0 reads 0.
- BYPASS=1: port 0 writes 42 to r3, read r3 same cycle → 42; BYPASS=0 same stimulus → old value (0) until edge, then 42.
- Reserve r7 → busy_read for r7 = 1, busy_any = 1; write r7 = 9 → busy 0, data 9; reserve and write r7 same cycle → busy stays 1, data updated.
- DEPTH=16, write 5 to address 20 → ignored; read address 20 → 0; NUM_READ=4 all reading r2 after write 0xA5 → all four return 0xA5.
- Write r10 = 100, assert ctrl_reset between edges → r10 reads 0 immediately; write issued during reset not stored.
